boot_mem_ctrl: RTL and testbench
================================

# boot_mem_ctrl

Parametrised word-addressed memory for the multicycle processor, with a built-in boot-loader port that streams the program image into RAM after reset, replacing file preload. Once loading completes, the block serves the processor through a request/acknowledge handshake with a configurable number of wait states. It sits between the processor's memory interface and the board/bench image source.

## Interface
- `DATA_W`, 64: word width in bits.
- `DEPTH`, 64: number of words; any value ≥ 2, not necessarily a power of two.
- `ADDR_W`, `$clog2(DEPTH)`: address width.
- `WAIT_STATES`, 2: extra cycles per processor access; legal range 0..15.
- `LOAD_WORDS`, `DEPTH`: words written by the loader before run mode; legal range 1..`DEPTH`.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `reset`, in, 1: reset, asynchronous and active-low.
- `ld_valid`, in, 1: loader word present.
- `ld_data`, in, `DATA_W`: loader word.
- `ld_ready`, out, 1: block accepts a loader word this cycle.
- `ld_done`, out, 1: image loaded; run mode active.
- `cpu_req`, in, 1: processor access request, held until ack.
- `cpu_we`, in, 1: 1 = write, 0 = read.
- `cpu_addr`, in, `ADDR_W`: word address.
- `cpu_wdata`, in, `DATA_W`: write data.
- `cpu_ack`, out, 1: one-cycle completion pulse.
- `cpu_rdata`, out, `DATA_W`: read data, registered.
- `cpu_err`, out, 1: valid with `cpu_ack`; 1 when the address is ≥ `DEPTH`.

## Operation
- **FSM states:** LOAD, IDLE, WAIT, ACCESS.
- **Reset** (`reset`=0) forces:
  - state = LOAD, load pointer = 0, wait counter = 0;
  - `ld_done`=0, `cpu_ack`=0, `cpu_err`=0, `cpu_rdata`=0.
  - RAM contents are not cleared.
- **LOAD:**
  - `ld_ready`=1.
  - Each cycle with `ld_valid`&&`ld_ready` writes `mem[ptr]` = `ld_data` and increments `ptr`.
  - On the write at `ptr` = `LOAD_WORDS`-1, go to IDLE. `ld_done`=1 from the next cycle until reset.
  - `cpu_req` is ignored in LOAD: no ack, nothing latched.
- **IDLE:**
  - `ld_ready`=0.
  - On `cpu_req`=1, latch `cpu_we`, `cpu_addr` and `cpu_wdata`, and load the counter with `WAIT_STATES`.
  - Go to WAIT if `WAIT_STATES`>0, otherwise go to ACCESS.
- **WAIT:** decrement the counter each cycle. Go to ACCESS in the cycle the counter reaches 1 → 0. Changes on the processor inputs during WAIT are ignored.
- **ACCESS:**
  - Perform the latched operation and assert `cpu_ack`=1 for this cycle only.
  - Read: `cpu_rdata` = `mem[addr]`.
  - Write: `mem[addr]` = `wdata`; `cpu_rdata` holds its previous value.
  - Address ≥ `DEPTH`: the write is dropped, a read returns 0, and `cpu_err`=1.
  - Return to IDLE.
- `cpu_rdata` holds until the next read completes.
- Loader words presented while `ld_ready`=0 are not consumed.

## Timing
- A request sampled at edge N gets `cpu_ack` high during cycle N+1+`WAIT_STATES`. With `WAIT_STATES`=0 the ack comes in the cycle after the request.
- **Back-to-back accesses:** if `cpu_req` stays high in the cycle after ack, a new request is sampled one cycle later, because IDLE is always visited. Maximum throughput is one access per `WAIT_STATES`+2 cycles.
- **Loader throughput:** one word per cycle. `ld_done` rises one cycle after the final word's edge.
- **Reset mid-operation** (any state): outputs return to their reset values immediately. An in-flight write is abandoned and memory is left unchanged for that access. Loading restarts at address 0.

## Structure
- **Shared package `mem_pkg`:**
  - FSM state enum `mem_state_t` {LOAD, IDLE, WAIT, ACCESS};
  - localparam `MAX_WAIT`=15;
  - request struct `mem_req_t` {`we`, `addr`, `wdata`}, parametrised via `DATA_W`/`ADDR_W` typedefs.
- **Sub-module `sp_ram`:** single-port synchronous RAM (`DATA_W` × `DEPTH`, write enable, registered read). The FSM, loader and wait counter live in `boot_mem_ctrl`.
- A parameter check at elaboration rejects `WAIT_STATES`>15 and `LOAD_WORDS`>`DEPTH`.

## Test plan
1. **Reset values.** Drive `reset`=0, then release it. Required: all outputs 0, `ld_ready`=1.
2. **Image load.** `LOAD_WORDS`=4; stream 0x11, 0x22, 0x33, 0x44 with a one-cycle `ld_valid` gap after the second word. Required: `ld_done` rises one cycle after 0x44 is accepted, and `ld_ready` falls at the same time.
3. **Read latency.** `WAIT_STATES`=2; read address 2 after the load. Required: `cpu_ack` for exactly one cycle, 3 cycles after request sampling, with `cpu_rdata`=0x33 and `cpu_err`=0. Repeat with `WAIT_STATES`=0: ack 1 cycle after sampling.
4. **Write then read back.** Write 0xDEADBEEF to address 1, then read address 1. Required: `cpu_rdata` unchanged on the write ack, 0xDEADBEEF on the read ack. A request held in LOAD gets no ack until `ld_done`.
5. **Out-of-range access.** `DEPTH`=48; write to address 50, then read address 50. Required: both acks carry `cpu_err`=1, the read returns 0, and words 0..47 are unchanged.
6. **Reset during WAIT.** Assert `reset` while a write to address 3 is in WAIT. Required: no ack; the FSM returns to LOAD with `ptr`=0; after reloading, address 3 holds its loaded value.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the boot-loading word memory: FSM states, wait-state limit and the
// processor request record.
package mem_pkg;

  typedef enum logic [1:0] {
    LOAD,
    IDLE,
    WAIT,
    ACCESS
  } mem_state_t;

  localparam int unsigned MAX_WAIT = 15;

  // Default-width request record; boot_mem_ctrl rebuilds the same shape at its own widths.
  localparam int unsigned MEM_DATA_W = 64;
  localparam int unsigned MEM_ADDR_W = 6;

  typedef logic [MEM_DATA_W-1:0] mem_data_t;
  typedef logic [MEM_ADDR_W-1:0] mem_addr_t;

  typedef struct packed {
    logic      we;
    mem_addr_t addr;
    mem_data_t wdata;
  } mem_req_t;

endpackage

// File: rtl/sp_ram.sv
// Single-port synchronous RAM with write enable and an enable-gated registered read port.
module sp_ram #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 64,
  parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/boot_mem_ctrl.sv
// Word memory that streams its program image in from a loader port after reset, then serves
// processor req/ack accesses with a fixed number of wait states.
module boot_mem_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = 64,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned ADDR_W      = $clog2(DEPTH),
  parameter int unsigned WAIT_STATES = 2,
  parameter int unsigned LOAD_WORDS  = DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              ld_done,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_err
);

  if (WAIT_STATES > MAX_WAIT) begin : g_bad_wait
    $error("boot_mem_ctrl: WAIT_STATES must be 0..15");
  end
  if (LOAD_WORDS == 0 || LOAD_WORDS > DEPTH) begin : g_bad_load
    $error("boot_mem_ctrl: LOAD_WORDS must be 1..DEPTH");
  end
  if (DEPTH < 2) begin : g_bad_depth
    $error("boot_mem_ctrl: DEPTH must be at least 2");
  end

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  function automatic logic in_range(input logic [ADDR_W-1:0] a);
    return 32'(a) < DEPTH;
  endfunction

  mem_state_t        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [3:0]        cnt_q, cnt_d;
  req_t              req_q, req_d;
  logic              done_q, done_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  // Forces cpu_rdata to zero after reset and after an out-of-range read.
  logic              zero_q, zero_d;

  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;
  logic              go_acc, acc_we;
  logic [ADDR_W-1:0] acc_addr;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    req_d     = req_q;
    done_d    = done_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    zero_d    = zero_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = req_q.addr;
    ram_wdata = req_q.wdata;
    go_acc    = 1'b0;
    acc_we    = req_q.we;
    acc_addr  = req_q.addr;
    ld_ready  = 1'b0;

    unique case (state_q)
      LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          ram_we    = 1'b1;
          ram_addr  = ptr_q;
          ram_wdata = ld_data;
          ptr_d     = ptr_q + 1'b1;
          if (32'(ptr_q) == LOAD_WORDS - 1) begin
            ptr_d   = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      IDLE: begin
        if (cpu_req) begin
          req_d.we    = cpu_we;
          req_d.addr  = cpu_addr;
          req_d.wdata = cpu_wdata;
          cnt_d       = 4'(WAIT_STATES);
          acc_we      = cpu_we;
          acc_addr    = cpu_addr;
          if (WAIT_STATES == 0) begin
            go_acc = 1'b1;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          go_acc = 1'b1;
        end
      end
      ACCESS: begin
        // Commit the write on the edge that leaves ACCESS so a reset here leaves RAM intact.
        state_d = IDLE;
        ram_we  = req_q.we && in_range(req_q.addr);
      end
      default: state_d = LOAD;
    endcase

    // Reads are issued on the edge entering ACCESS so data is ready alongside the ack.
    if (go_acc) begin
      state_d = ACCESS;
      ack_d   = 1'b1;
      err_d   = !in_range(acc_addr);
      if (!acc_we) begin
        if (in_range(acc_addr)) begin
          ram_re   = 1'b1;
          ram_addr = acc_addr;
          zero_d   = 1'b0;
        end else begin
          zero_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD;
      ptr_q   <= '0;
      cnt_q   <= '0;
      req_q   <= '0;
      done_q  <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      zero_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      done_q  <= done_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      zero_q  <= zero_d;
    end
  end

  sp_ram #(
    .DATA_W(DATA_W),
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .we_i   (ram_we & reset),
    .re_i   (ram_re & reset),
    .addr_i (ram_addr),
    .wdata_i(ram_wdata),
    .rdata_o(ram_rdata)
  );

  assign ld_done   = done_q;
  assign cpu_ack   = ack_q;
  assign cpu_err   = err_q;
  assign cpu_rdata = zero_q ? '0 : ram_rdata;

endmodule

// File: tb/tb_boot_mem_ctrl.sv
// Directed bench for boot_mem_ctrl: one instance with two wait states, one with none,
// both 48 words deep with a 4-word boot image.
module tb_boot_mem_ctrl;

  localparam int unsigned DW = 64;
  localparam int unsigned DEPTH = 48;
  localparam int unsigned AW = 6;
  localparam int unsigned LW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ld_valid;
  logic [DW-1:0] ld_data;

  logic          ld_ready_a, ld_done_a, cpu_req_a, cpu_we_a, cpu_ack_a, cpu_err_a;
  logic [AW-1:0] cpu_addr_a;
  logic [DW-1:0] cpu_wdata_a, cpu_rdata_a;

  logic          ld_ready_b, ld_done_b, cpu_req_b, cpu_we_b, cpu_ack_b, cpu_err_b;
  logic [AW-1:0] cpu_addr_b;
  logic [DW-1:0] cpu_wdata_b, cpu_rdata_b;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  boot_mem_ctrl #(
    .DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(2), .LOAD_WORDS(LW)
  ) dut_a (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready_a), .ld_done(ld_done_a), .cpu_req(cpu_req_a), .cpu_we(cpu_we_a),
    .cpu_addr(cpu_addr_a), .cpu_wdata(cpu_wdata_a), .cpu_ack(cpu_ack_a),
    .cpu_rdata(cpu_rdata_a), .cpu_err(cpu_err_a)
  );

  boot_mem_ctrl #(
    .DATA_W(DW), .DEPTH(DEPTH), .WAIT_STATES(0), .LOAD_WORDS(LW)
  ) dut_b (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_ready(ld_ready_b), .ld_done(ld_done_b), .cpu_req(cpu_req_b), .cpu_we(cpu_we_b),
    .cpu_addr(cpu_addr_b), .cpu_wdata(cpu_wdata_b), .cpu_ack(cpu_ack_b),
    .cpu_rdata(cpu_rdata_b), .cpu_err(cpu_err_b)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Streams four words; optional one-cycle ld_valid gap after the second.
  task automatic load_image(input logic [63:0] w0, input logic [63:0] w1,
                            input logic [63:0] w2, input logic [63:0] w3, input bit gap);
    ld_valid = 1'b1;
    ld_data  = w0;
    tick();
    ld_data = w1;
    tick();
    if (gap) begin
      ld_valid = 1'b0;
      tick();
      check_eq("ready_in_gap", ld_ready_a, 1);
      ld_valid = 1'b1;
    end
    ld_data = w2;
    tick();
    ld_data = w3;
    check_eq("done_before_last", ld_done_a, 0);
    check_eq("ready_before_last", ld_ready_a, 1);
    check_eq("no_ack_in_load", cpu_ack_a, 0);
    tick();
    ld_valid = 1'b0;
    check_eq("done_after_last", ld_done_a, 1);
    check_eq("ready_after_last", ld_ready_a, 0);
    check_eq("done_after_last_b", ld_done_b, 1);
  endtask

  // Issues one access on instance A; lat counts edges from sampling to the visible ack.
  task automatic access_a(input logic we, input logic [AW-1:0] addr, input logic [63:0] wd,
                          output int lat, output logic [63:0] rd, output logic err);
    cpu_req_a   = 1'b1;
    cpu_we_a    = we;
    cpu_addr_a  = addr;
    cpu_wdata_a = wd;
    lat = 0;
    rd  = '0;
    err = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cpu_ack_a) begin
        lat = i;
        rd  = cpu_rdata_a;
        err = cpu_err_a;
        break;
      end
    end
    cpu_req_a = 1'b0;
    tick();
    check_eq("ack_single_cycle", cpu_ack_a, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected $finish before 200000");
    $fatal(1);
  end

  initial begin
    int            lat;
    logic [63:0]   rd;
    logic          err;
    logic [63:0]   exp_img [4];

    reset = 1'b0;
    ld_valid = 1'b0;
    ld_data = '0;
    cpu_req_a = 1'b0; cpu_we_a = 1'b0; cpu_addr_a = '0; cpu_wdata_a = '0;
    cpu_req_b = 1'b0; cpu_we_b = 1'b0; cpu_addr_b = '0; cpu_wdata_b = '0;
    tick();
    tick();

    check_eq("rst_ld_ready", ld_ready_a, 1);
    check_eq("rst_ld_done", ld_done_a, 0);
    check_eq("rst_ack", cpu_ack_a, 0);
    check_eq("rst_err", cpu_err_a, 0);
    check_eq("rst_rdata", cpu_rdata_a, 0);
    check_eq("rst_ld_ready_b", ld_ready_b, 1);
    reset = 1'b1;
    tick();
    check_eq("post_rst_ld_ready", ld_ready_a, 1);
    check_eq("post_rst_ld_done", ld_done_a, 0);

    // Read of address 2 held on A throughout the load must wait for ld_done.
    cpu_req_a = 1'b1; cpu_we_a = 1'b0; cpu_addr_a = 6'd2;
    load_image(64'h11, 64'h22, 64'h33, 64'h44, 1'b1);

    cpu_req_b = 1'b1; cpu_we_b = 1'b0; cpu_addr_b = 6'd2;
    tick();
    check_eq("b_ack_ws0", cpu_ack_b, 1);
    check_eq("b_rdata_ws0", cpu_rdata_b, 64'h33);
    check_eq("b_err_ws0", cpu_err_b, 0);
    check_eq("a_wait1", cpu_ack_a, 0);
    cpu_req_b = 1'b0;
    tick();
    check_eq("b_ack_drop", cpu_ack_b, 0);
    check_eq("a_wait2", cpu_ack_a, 0);
    tick();
    check_eq("a_ack_ws2", cpu_ack_a, 1);
    check_eq("a_rdata_ws2", cpu_rdata_a, 64'h33);
    check_eq("a_err_ws2", cpu_err_a, 0);
    cpu_req_a = 1'b0;
    tick();
    check_eq("a_ack_drop", cpu_ack_a, 0);

    // Held request on B: IDLE is revisited, so acks are two cycles apart.
    cpu_req_b = 1'b1; cpu_addr_b = 6'd3;
    tick();
    check_eq("b2b_first", cpu_ack_b, 1);
    check_eq("b2b_first_data", cpu_rdata_b, 64'h44);
    tick();
    check_eq("b2b_gap", cpu_ack_b, 0);
    tick();
    check_eq("b2b_second", cpu_ack_b, 1);
    cpu_req_b = 1'b0;
    tick();
    check_eq("b2b_after", cpu_ack_b, 0);

    access_a(1'b1, 6'd1, 64'hDEADBEEF, lat, rd, err);
    check_eq("wr_lat", 64'(lat), 3);
    check_eq("wr_rdata_held", rd, 64'h33);
    check_eq("wr_err", err, 0);
    access_a(1'b0, 6'd1, 64'h0, lat, rd, err);
    check_eq("rd_back_lat", 64'(lat), 3);
    check_eq("rd_back_data", rd, 64'hDEADBEEF);

    access_a(1'b1, 6'd50, 64'hBAD, lat, rd, err);
    check_eq("oor_wr_err", err, 1);
    check_eq("oor_wr_rdata_held", rd, 64'hDEADBEEF);
    access_a(1'b0, 6'd50, 64'h0, lat, rd, err);
    check_eq("oor_rd_err", err, 1);
    check_eq("oor_rd_zero", rd, 0);
    check_eq("oor_rd_lat", 64'(lat), 3);

    exp_img[0] = 64'h11; exp_img[1] = 64'hDEADBEEF; exp_img[2] = 64'h33; exp_img[3] = 64'h44;
    for (int i = 0; i < 4; i++) begin
      access_a(1'b0, AW'(i), 64'h0, lat, rd, err);
      check_eq($sformatf("img_rd%0d", i), rd, exp_img[i]);
      check_eq($sformatf("img_err%0d", i), err, 0);
    end

    // Reset while a write to address 3 sits in WAIT.
    cpu_req_a = 1'b1; cpu_we_a = 1'b1; cpu_addr_a = 6'd3; cpu_wdata_a = 64'h5555;
    tick();
    tick();
    reset = 1'b0;
    cpu_req_a = 1'b0;
    #1;
    check_eq("midrst_ack", cpu_ack_a, 0);
    check_eq("midrst_ld_ready", ld_ready_a, 1);
    check_eq("midrst_ld_done", ld_done_a, 0);
    check_eq("midrst_rdata", cpu_rdata_a, 0);
    tick();
    check_eq("midrst_ack_later", cpu_ack_a, 0);
    reset = 1'b1;
    tick();
    load_image(64'hA0, 64'hA1, 64'hA2, 64'hA3, 1'b0);
    access_a(1'b0, 6'd3, 64'h0, lat, rd, err);
    check_eq("reload_addr3", rd, 64'hA3);
    access_a(1'b0, 6'd0, 64'h0, lat, rd, err);
    check_eq("reload_addr0", rd, 64'hA0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
